// File: rtl/fan_alarm_driver_pkg.sv
// Shared encodings for fan_alarm_driver and the upstream fan/alarm controller FSM.
package fan_alarm_driver_pkg;

    typedef enum logic [1:0] {
        BeepIdle = 2'd0,
        BeepOn   = 2'd1,
        BeepOff  = 2'd2
    } beep_state_e;

    // Controller state codes, identical to the encoding driven on Estado.
    typedef enum logic [1:0] {
        CtrlState0 = 2'd0,
        CtrlState1 = 2'd1,
        CtrlState2 = 2'd2,
        CtrlState3 = 2'd3
    } ctrl_state_e;

    localparam int unsigned DUTY_W   = 4;
    localparam logic [3:0]  DUTY_MAX = 4'd15;

    localparam logic [3:0] LED_STATE0 = 4'b0001;
    localparam logic [3:0] LED_STATE1 = 4'b0010;
    localparam logic [3:0] LED_STATE2 = 4'b0100;
    localparam logic [3:0] LED_STATE3 = 4'b1000;

    function automatic logic [3:0] led_decode(input logic [1:0] state);
        logic [3:0] leds;
        leds = LED_STATE0;
        unique case (ctrl_state_e'(state))
            CtrlState0: leds = LED_STATE0;
            CtrlState1: leds = LED_STATE1;
            CtrlState2: leds = LED_STATE2;
            CtrlState3: leds = LED_STATE3;
            default:    leds = LED_STATE0;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running 4-bit PWM: counter plus registered compare against the current duty.
module fan_pwm_gen
    import fan_alarm_driver_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DUTY_W-1:0] duty,
    output logic              Fan_PWM
);

    logic [DUTY_W-1:0] r_cnt;
    logic              r_pwm;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= r_cnt + DUTY_W'(1);
            r_pwm <= (r_cnt < duty);
        end
    end

    assign Fan_PWM = r_pwm;

endmodule

// File: rtl/fan_alarm_driver.sv
// Fan/alarm back end: soft-ramped PWM fan, pulsed buzzer and one-hot state LEDs.
// Optional FAN_BOOST_EN: while Alarma is high the fan duty is forced to full scale.
module fan_alarm_driver
    import fan_alarm_driver_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 4,
    parameter int unsigned BEEP_ON_CYC  = 3,
    parameter int unsigned BEEP_OFF_CYC = 2
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Ventilador,
    input  logic       Alarma,
    input  logic [1:0] Estado,
    output logic       Fan_PWM,
    output logic [3:0] Fan_Duty,
    output logic       Buzzer,
    output logic [3:0] LEDs
);

    localparam int unsigned PRESC_W  = $clog2(TICK_DIV);
    localparam int unsigned BEEP_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
    localparam int unsigned BEEP_CW  = (BEEP_MAX > 1) ? $clog2(BEEP_MAX) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [BEEP_CW-1:0] ON_LAST    = BEEP_CW'(BEEP_ON_CYC - 1);
    localparam logic [BEEP_CW-1:0] OFF_LAST   = BEEP_CW'(BEEP_OFF_CYC - 1);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;
    logic [3:0]         r_duty;
    logic [3:0]         w_duty_next;
    beep_state_e        r_beep_state;
    beep_state_e        w_beep_state_next;
    logic [BEEP_CW-1:0] r_beep_cnt;
    logic [BEEP_CW-1:0] w_beep_cnt_next;
    logic               r_alarm_q;
    logic               r_buzzer;
    logic [3:0]         r_leds;

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Ramp uses the current Ventilador, so a request change on a tick cycle takes effect at once.
    always_comb begin
        w_duty_next = r_duty;
        if (w_tick) begin
            if (Ventilador && (r_duty != DUTY_MAX)) begin
                w_duty_next = r_duty + 4'd1;
            end else if (!Ventilador && (r_duty != 4'd0)) begin
                w_duty_next = r_duty - 4'd1;
            end
        end
`ifdef FAN_BOOST_EN
        if (Alarma) begin
            w_duty_next = DUTY_MAX;
        end
`else
`endif
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_duty <= 4'd0;
        end else begin
            r_duty <= w_duty_next;
        end
    end

    fan_pwm_gen u_fan_pwm_gen (
        .CLK     (CLK),
        .Reset   (Reset),
        .duty    (r_duty),
        .Fan_PWM (Fan_PWM)
    );

    always_comb begin
        w_beep_state_next = r_beep_state;
        w_beep_cnt_next   = r_beep_cnt;
        unique case (r_beep_state)
            BeepIdle: begin
                if (Alarma && !r_alarm_q) begin
                    w_beep_state_next = BeepOn;
                    w_beep_cnt_next   = '0;
                end
            end
            BeepOn: begin
                if (!Alarma) begin
                    w_beep_state_next = BeepIdle;
                    w_beep_cnt_next   = '0;
                end else if (r_beep_cnt == ON_LAST) begin
                    w_beep_state_next = BeepOff;
                    w_beep_cnt_next   = '0;
                end else begin
                    w_beep_cnt_next = r_beep_cnt + BEEP_CW'(1);
                end
            end
            BeepOff: begin
                if (!Alarma) begin
                    w_beep_state_next = BeepIdle;
                    w_beep_cnt_next   = '0;
                end else if (r_beep_cnt == OFF_LAST) begin
                    w_beep_state_next = BeepOn;
                    w_beep_cnt_next   = '0;
                end else begin
                    w_beep_cnt_next = r_beep_cnt + BEEP_CW'(1);
                end
            end
            default: begin
                w_beep_state_next = BeepIdle;
                w_beep_cnt_next   = '0;
            end
        endcase
    end

    // Buzzer register mirrors the next beep state so it is high exactly while in BeepOn.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_beep_state <= BeepIdle;
            r_beep_cnt   <= '0;
            r_alarm_q    <= 1'b0;
            r_buzzer     <= 1'b0;
            r_leds       <= LED_STATE0;
        end else begin
            r_beep_state <= w_beep_state_next;
            r_beep_cnt   <= w_beep_cnt_next;
            r_alarm_q    <= Alarma;
            r_buzzer     <= (w_beep_state_next == BeepOn);
            r_leds       <= led_decode(Estado);
        end
    end

    assign Fan_Duty = r_duty;
    assign Buzzer   = r_buzzer;
    assign LEDs     = r_leds;

endmodule

// File: doc/fan_alarm_driver.md
Name: fan_alarm_driver

Overview:
Actuator/indicator back end for the fan/alarm controller FSM. It consumes that FSM's Ventilador, Alarma and Estado outputs. It drives:
- a soft-start/soft-stop PWM fan output,
- a pulsed buzzer pattern,
- a one-hot state LED bank.
It sits between the controller FSM and the board pins, in the same CLK domain.

Parameters:
TICK_DIV, 4, ramp prescaler period in CLK cycles (≥2); one duty step per tick
BEEP_ON_CYC, 3, buzzer high duration in CLK cycles (≥1)
BEEP_OFF_CYC, 2, buzzer low gap in CLK cycles (≥1)

Ports:
CLK  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
Ventilador  in  1  fan request from controller FSM
Alarma  in  1  alarm request from controller FSM
Estado  in  2  controller state code (0..3)
Fan_PWM  out  1  registered fan PWM output
Fan_Duty  out  4  current duty, 0..15
Buzzer  out  1  registered buzzer drive
LEDs  out  4  registered one-hot state indicator

Behaviour:
- Reset (sampled at rising edge) → next cycle: Fan_PWM=0, Fan_Duty=0, Buzzer=0, LEDs=4'b0001, prescaler=0, PWM counter=0, beep FSM=IDLE, alarm-history reg=0. Reset overrides everything, including mid-ramp and mid-beep.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when count==TICK_DIV-1.
- Duty ramp, evaluated on tick only:
  - Ventilador=1 and duty<15 → duty+1.
  - Ventilador=0 and duty>0 → duty-1.
  - Saturates at 0 and 15, no wrap.
  - Non-tick cycles hold duty.
- PWM:
  - 4-bit counter increments every cycle and wraps 15→0.
  - Fan_PWM <= (pwm_cnt < duty), registered, so it lags the compare by 1 cycle.
  - duty=0 → constant 0. duty=15 → high 15 of every 16 cycles.
- Beep FSM states: IDLE, BEEP_ON, BEEP_OFF. It has a cycle counter and an alarm_q register (Alarma delayed 1 cycle). Buzzer is registered and equals 1 exactly while in BEEP_ON.
  - IDLE: Alarma & !alarm_q (rising edge) → BEEP_ON, counter=0. Alarma already high out of reset counts as a rising edge, since alarm_q resets to 0.
  - BEEP_ON: Alarma=0 → IDLE. Else counter==BEEP_ON_CYC-1 → BEEP_OFF, counter=0. Else counter+1.
  - BEEP_OFF: Alarma=0 → IDLE. Else counter==BEEP_OFF_CYC-1 → BEEP_ON, counter=0. Else counter+1.
  - Alarma drop in any state → Buzzer=0 on the next edge.
- LEDs <= 1<<Estado, 1-cycle latency: 0→0001, 1→0010, 2→0100, 3→1000.
- No cross-checking of input legality (e.g. Alarma=1 with Ventilador=0): each output path obeys only its own input.
- Simultaneous events: a tick and a Ventilador change in the same cycle use the new Ventilador value.

Optional Feature:
FAN_BOOST_EN.
- Defined: while Alarma=1, duty is forced to 15 on the next edge regardless of tick. Releasing Alarma resumes normal ramping from 15.
- Undefined: Alarma does not affect duty; the ramp is the only duty path.

Decomposition:
- Shared package holds:
  - beep state encoding (IDLE=2'd0, BEEP_ON=2'd1, BEEP_OFF=2'd2),
  - DUTY_MAX=4'd15,
  - LED one-hot constants,
  - the controller state codes 0..3, shared with the controller FSM.
- One sub-module: fan_pwm_gen, containing the 4-bit PWM counter plus compare. Inputs: CLK, Reset, duty. Output: Fan_PWM.
- The ramp, beep FSM and LED decode stay in the top module.

Test Plan:
- Reset held 2 cycles with all inputs 1 → Fan_PWM=0, Fan_Duty=0, Buzzer=0, LEDs=0001 during and 1 cycle after Reset.
- Ventilador=1 from reset release → Fan_Duty 1,2,…,15 at 4-cycle spacing; still 15 after 80 cycles; Fan_PWM then 15-high/1-low per 16 cycles.
- Ventilador 1→0 at duty 15 → duty decrements every 4 cycles to 0 in 60 cycles; Fan_PWM stays 0 thereafter.
- Alarma 0→1 and held → Buzzer pattern 1,1,1,0,0 repeating. Alarma dropped at 2nd BEEP_ON cycle → Buzzer 0 next cycle. Re-raised → fresh 3-cycle high.
- Estado stepped 0,1,2,3 on consecutive cycles → LEDs 0001,0010,0100,1000, each one cycle later. Reset asserted with duty=7 → duty=0 next cycle.
- With FAN_BOOST_EN defined, duty=3 and Alarma raised → Fan_Duty=15 next cycle. Without the macro → duty keeps ramping 4,5,… per tick.
